// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF->ID fetch handshake plus the registered ID/EX payload.
// The fetch side (and whatever observes EX) uses the master modport.
// The decode stage uses the slave modport.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_wr_en;
  logic            ex_data_rd_en;
  logic            ex_data_wr_en;
  logic [2:0]      ex_funct3;
  logic [3:0]      ex_alu_op;
  logic            ex_alu_src1;
  logic            ex_alu_src2;
  logic            ex_cond_jump;
  logic            ex_uncond_jump;
  logic            ex_base_addr_sel;
  logic            ex_illegal;

  modport master (
    output if_valid, if_inst, if_pc, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_rd_addr,
           ex_rd_wr_en, ex_data_rd_en, ex_data_wr_en, ex_funct3, ex_alu_op,
           ex_alu_src1, ex_alu_src2, ex_cond_jump, ex_uncond_jump,
           ex_base_addr_sel, ex_illegal
  );

  modport slave (
    input  if_valid, if_inst, if_pc, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_rd_addr,
           ex_rd_wr_en, ex_data_rd_en, ex_data_wr_en, ex_funct3, ex_alu_op,
           ex_alu_src1, ex_alu_src2, ex_cond_jump, ex_uncond_jump,
           ex_base_addr_sel, ex_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32/RV64 integer decode stage.
// It holds the ID/EX pipeline register, a load-use interlock and a saturating bubble counter.
// Optional feature, selected by macro ID_WB_BYPASS_EN: the write-back port is forwarded
// into the operand read. When the macro is undefined, the wb_* inputs are ignored.
// XLEN must be 32 or 64.
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_pipe_if.slave   bus,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_rdata,
  input  logic [XLEN-1:0]  rs2_rdata,
  input  logic             wb_rd_wr_en,
  input  logic [4:0]       wb_rd_addr,
  input  logic [XLEN-1:0]  wb_rd_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU codes: {funct7[5],funct3} for arithmetic.
  // Two spare encodings are used for "PC+4" (link) and "pass operand 2".
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADD4 = 4'b1010;
  localparam logic [3:0] ALU_BPS2 = 4'b1011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic            rd_wr_en;
    logic            data_rd_en;
    logic            data_wr_en;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            alu_src1;
    logic            alu_src2;
    logic            cond_jump;
    logic            uncond_jump;
    logic            base_addr_sel;
    logic            illegal;
  } payload_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0]     inst_s;
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic            rs1_used_s;
  logic            rs2_used_s;
  logic            writes_rd_s;
  logic            hazard_s;
  logic            advance_s;
  payload_t        pl_d;
  payload_t        pl_q;
  logic            ex_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign inst_s   = bus.if_inst;
  assign opcode_s = inst_s[6:0];
  assign funct3_s = inst_s[14:12];
  assign rd_s     = inst_s[11:7];
  assign rs1_addr = inst_s[19:15];
  assign rs2_addr = inst_s[24:20];

`ifdef ID_WB_BYPASS_EN
  // Forward a same-cycle write-back so the operand is not read stale; x0 never forwards.
  always_comb begin
    if (wb_rd_wr_en && (wb_rd_addr == rs1_addr) && (rs1_addr != 5'd0)) begin
      rs1_val_s = wb_rd_data;
    end else begin
      rs1_val_s = rs1_rdata;
    end
    if (wb_rd_wr_en && (wb_rd_addr == rs2_addr) && (rs2_addr != 5'd0)) begin
      rs2_val_s = wb_rd_data;
    end else begin
      rs2_val_s = rs2_rdata;
    end
  end
`else
  logic unused_wb_s;
  assign rs1_val_s   = rs1_rdata;
  assign rs2_val_s   = rs2_rdata;
  assign unused_wb_s = ^{wb_rd_wr_en, wb_rd_addr, wb_rd_data};
`endif

  // Decode the presented instruction into the next ID/EX payload and operand-usage flags.
  always_comb begin
    pl_d          = '0;
    pl_d.pc       = bus.if_pc;
    pl_d.rs1      = rs1_val_s;
    pl_d.rs2      = rs2_val_s;
    pl_d.rd_addr  = rd_s;
    pl_d.funct3   = funct3_s;
    pl_d.alu_op   = ALU_ADD;
    writes_rd_s   = 1'b0;
    rs1_used_s    = 1'b1;
    rs2_used_s    = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        pl_d.imm      = sext32({inst_s[31:12], 12'h000});
        pl_d.alu_op   = ALU_BPS2;
        pl_d.alu_src2 = 1'b1;
        writes_rd_s   = 1'b1;
        rs1_used_s    = 1'b0;
      end
      OPC_AUIPC: begin
        pl_d.imm      = sext32({inst_s[31:12], 12'h000});
        pl_d.alu_src1 = 1'b1;
        pl_d.alu_src2 = 1'b1;
        writes_rd_s   = 1'b1;
        rs1_used_s    = 1'b0;
      end
      OPC_JAL: begin
        pl_d.imm         = sext32({{11{inst_s[31]}}, inst_s[31], inst_s[19:12],
                                   inst_s[20], inst_s[30:21], 1'b0});
        pl_d.alu_op      = ALU_ADD4;
        pl_d.alu_src1    = 1'b1;
        pl_d.uncond_jump = 1'b1;
        writes_rd_s      = 1'b1;
        rs1_used_s       = 1'b0;
      end
      OPC_JALR: begin
        pl_d.imm           = sext32({{20{inst_s[31]}}, inst_s[31:20]});
        pl_d.alu_op        = ALU_ADD4;
        pl_d.alu_src1      = 1'b1;
        pl_d.uncond_jump   = 1'b1;
        pl_d.base_addr_sel = 1'b1;
        writes_rd_s        = 1'b1;
      end
      OPC_BRANCH: begin
        pl_d.imm       = sext32({{19{inst_s[31]}}, inst_s[31], inst_s[7],
                                 inst_s[30:25], inst_s[11:8], 1'b0});
        pl_d.cond_jump = 1'b1;
        rs2_used_s     = 1'b1;
      end
      OPC_LOAD: begin
        pl_d.imm        = sext32({{20{inst_s[31]}}, inst_s[31:20]});
        pl_d.alu_src2   = 1'b1;
        pl_d.data_rd_en = 1'b1;
        writes_rd_s     = 1'b1;
      end
      OPC_STORE: begin
        pl_d.imm        = sext32({{20{inst_s[31]}}, inst_s[31:25], inst_s[11:7]});
        pl_d.alu_src2   = 1'b1;
        pl_d.data_wr_en = 1'b1;
        rs2_used_s      = 1'b1;
      end
      OPC_OPIMM: begin
        pl_d.imm      = sext32({{20{inst_s[31]}}, inst_s[31:20]});
        pl_d.alu_src2 = 1'b1;
        writes_rd_s   = 1'b1;
        // Only the shift-right pair uses funct7[5] (SRLI vs SRAI); for other ops those bits are immediate.
        if (funct3_s == 3'b101) begin
          pl_d.alu_op = {inst_s[30], funct3_s};
        end else begin
          pl_d.alu_op = {1'b0, funct3_s};
        end
      end
      OPC_OP: begin
        pl_d.alu_op = {inst_s[30], funct3_s};
        writes_rd_s = 1'b1;
        rs2_used_s  = 1'b1;
      end
      OPC_FENCE: begin
        pl_d.imm = '0;
      end
      OPC_SYSTEM: begin
        pl_d.imm = sext32({{20{inst_s[31]}}, inst_s[31:20]});
      end
      default: begin
        pl_d.illegal = 1'b1;
      end
    endcase
    pl_d.rd_wr_en = writes_rd_s && (rd_s != 5'd0);
  end

  // Load-use interlock and pipeline advance; the ready output is masked by flush and reset.
  always_comb begin
    advance_s = !ex_valid_q || bus.ex_ready;
    if (bus.if_valid && ex_valid_q && pl_q.data_rd_en && (pl_q.rd_addr != 5'd0)) begin
      hazard_s = (rs1_used_s && (pl_q.rd_addr == rs1_addr)) ||
                 (rs2_used_s && (pl_q.rd_addr == rs2_addr));
    end else begin
      hazard_s = 1'b0;
    end
    bus.id_ready = advance_s && !hazard_s && !flush && !rst;
  end

  // ID/EX register: reset, then flush, then hold on EX back-pressure, then bubble, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      pl_q        <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (!advance_s) begin
      ex_valid_q <= ex_valid_q;
    end else if (hazard_s) begin
      ex_valid_q <= 1'b0;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end else begin
      ex_valid_q <= bus.if_valid;
      pl_q       <= pl_d;
    end
  end

  assign stall_cnt            = stall_cnt_q;
  assign bus.ex_valid         = ex_valid_q;
  assign bus.ex_pc            = pl_q.pc;
  assign bus.ex_rs1           = pl_q.rs1;
  assign bus.ex_rs2           = pl_q.rs2;
  assign bus.ex_imm           = pl_q.imm;
  assign bus.ex_rd_addr       = pl_q.rd_addr;
  assign bus.ex_rd_wr_en      = pl_q.rd_wr_en;
  assign bus.ex_data_rd_en    = pl_q.data_rd_en;
  assign bus.ex_data_wr_en    = pl_q.data_wr_en;
  assign bus.ex_funct3        = pl_q.funct3;
  assign bus.ex_alu_op        = pl_q.alu_op;
  assign bus.ex_alu_src1      = pl_q.alu_src1;
  assign bus.ex_alu_src2      = pl_q.alu_src2;
  assign bus.ex_cond_jump     = pl_q.cond_jump;
  assign bus.ex_uncond_jump   = pl_q.uncond_jump;
  assign bus.ex_base_addr_sel = pl_q.base_addr_sel;
  assign bus.ex_illegal       = pl_q.illegal;

endmodule
